rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Write-side initiator for the 32x32 register file: the single master that drives the file's write enable, write address and write data.
- Merges two result producers. The single-cycle ALU path carries no backpressure. The multi-cycle mul/div unit uses a valid/ready handshake and is buffered in a small FIFO.
- Presents one registered write per cycle to the register file.
- Provides a per-register busy query so decode can stall on pending writebacks.

Parameters:
- DEPTH, 4, number of FIFO entries for mul/div results (power of two, 2..16).
- STARVE_LIMIT, 8, consecutive cycles the ALU may hold priority over a non-empty FIFO before a stall is forced.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid_i  in  1  ALU result present this cycle.
- alu_wa_i  in  5  ALU destination register.
- alu_wd_i  in  32  ALU result data.
- md_valid_i  in  1  mul/div result offered.
- md_ready_o  out  1  arbiter can accept a mul/div result.
- md_wa_i  in  5  mul/div destination register.
- md_wd_i  in  32  mul/div result data.
- chk_ra_i  in  5  register number queried by decode.
- busy_o  out  1  chk_ra_i has a write pending (FIFO or output stage).
- alu_stall_o  out  1  pipeline must not present alu_valid_i this cycle.
- RegWrite_o  out  1  register file write enable.
- wa_o  out  5  register file write address.
- wd_o  out  32  register file write data.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at clk edge): RegWrite_o=0, wa_o=0, wd_o=0, FIFO emptied (count_o=0), starvation counter=0, err_o=0. Reset overrides all inputs, including mid-drain; discarded entries are never written.
- md_ready_o = (count_o < DEPTH). It depends only on registered state.
- Mul/div handshake: a transfer occurs when md_valid_i=1 and md_ready_o=1.
  - A transferred entry with md_wa_i≠0 is pushed at the FIFO tail.
  - An entry with md_wa_i=0 is accepted and discarded.
- Effective ALU write: alu_valid_i=1 and alu_wa_i≠0. An ALU write to register 0 counts as no write.
- Output stage, registered, updated every cycle in this priority order:
  1. alu_stall_o=1 and FIFO non-empty: pop head, RegWrite_o=1, wa_o/wd_o=head.
  2. Else, effective ALU write: RegWrite_o=1, wa_o=alu_wa_i, wd_o=alu_wd_i.
  3. Else, FIFO non-empty: pop head and write it.
  4. Else: RegWrite_o=0; wa_o/wd_o hold their values.
- Latency:
  - ALU: 1 cycle, input to RegWrite_o.
  - Mul/div: minimum 2 cycles, handshake to RegWrite_o. The FIFO has no bypass.
- Same-cycle push and pop are both performed; count is unchanged. When full, ready=0, so no push occurs even if a pop happens that cycle.
- FIFO ordering: strict in order. Pointers are DEPTH-modulo and wrap. Occupancy is tracked by count_o, so full and empty are unambiguous.
- Starvation counter:
  - Increments when the FIFO is non-empty and the ALU wins the output stage.
  - Clears on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - alu_stall_o = (counter == STARVE_LIMIT) && FIFO non-empty (combinational).
- err_o: set when alu_valid_i=1 while alu_stall_o=1; the ALU result is dropped. err_o is cleared only by rst.
- busy_o: combinational. busy_o=1 when chk_ra_i≠0 and any of:
  - any valid FIFO entry has wa == chk_ra_i;
  - RegWrite_o=1 and wa_o == chk_ra_i.
- busy_o is always 0 for chk_ra_i=0.
- Ordering hazard: an ALU write and a buffered mul/div write to the same register may retire out of program order. Decode must stall on busy_o before issuing any instruction that writes a busy register.

Test Plan:
- Reset then idle → RegWrite_o=0, count_o=0, md_ready_o=1, busy_o=0 for every chk_ra_i.
- ALU only: alu_valid_i=1, wa=5, wd=0x12345678 at cycle 0 → cycle 1: RegWrite_o=1, wa_o=5, wd_o=0x12345678. Same stimulus with wa=0 → RegWrite_o=0.
- Mul/div fill, DEPTH=4, ALU busy: push wa=8..11 in 4 cycles while ALU writes wa=2 every cycle → count_o=4, md_ready_o=0, and busy_o=1 for chk_ra_i=9.
  - Release the ALU → RegWrite_o writes regs 8, 9, 10, 11 on consecutive cycles, then count_o=0.
- Starvation, STARVE_LIMIT=8: one FIFO entry (wa=3) with ALU valid every cycle → alu_stall_o=1 after 8 ALU wins. The next cycle writes wa_o=3, then alu_stall_o=0.
  - Driving alu_valid_i during the stall cycle → err_o=1, sticky until rst.
- Simultaneous push/pop with count_o=2 and no ALU write → one write out, one entry in, count_o stays 2, order preserved.
- Reset mid-operation with count_o=3 → next cycle count_o=0, RegWrite_o=0, and none of the three entries is ever written.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: register-file write-side arbiter. It merges the ALU path and a FIFO-buffered
// mul/div path into one registered write per cycle, and answers per-register busy queries.
`default_nettype none

module rf_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid_i,
  input  logic [4:0]               alu_wa_i,
  input  logic [31:0]              alu_wd_i,
  input  logic                     md_valid_i,
  output logic                     md_ready_o,
  input  logic [4:0]               md_wa_i,
  input  logic [31:0]              md_wd_i,
  input  logic [4:0]               chk_ra_i,
  output logic                     busy_o,
  output logic                     alu_stall_o,
  output logic                     RegWrite_o,
  output logic [4:0]               wa_o,
  output logic [31:0]              wd_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    wa_mem_q [DEPTH];
  logic [4:0]    wa_mem_d [DEPTH];
  logic [31:0]   wd_mem_q [DEPTH];
  logic [31:0]   wd_mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic          err_q, err_d;

  logic fifo_empty, push, pop, alu_eff;

  assign fifo_empty  = (count_q == '0);
  assign md_ready_o  = (count_q < CW'(DEPTH));
  assign push        = md_valid_i && md_ready_o && (md_wa_i != 5'd0);
  assign alu_eff     = alu_valid_i && (alu_wa_i != 5'd0);
  assign alu_stall_o = (starve_q == SW'(STARVE_LIMIT)) && !fifo_empty;

  // Output stage priority: forced drain, then ALU, then opportunistic drain.
  always_comb begin
    regwrite_d = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    pop        = 1'b0;
    if (alu_stall_o) begin
      pop        = 1'b1;
      regwrite_d = 1'b1;
      wa_d       = wa_mem_q[rd_ptr_q];
      wd_d       = wd_mem_q[rd_ptr_q];
    end else if (alu_eff) begin
      regwrite_d = 1'b1;
      wa_d       = alu_wa_i;
      wd_d       = alu_wd_i;
    end else if (!fifo_empty) begin
      pop        = 1'b1;
      regwrite_d = 1'b1;
      wa_d       = wa_mem_q[rd_ptr_q];
      wd_d       = wd_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    wa_mem_d = wa_mem_q;
    wd_mem_d = wd_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wa_mem_d[wr_ptr_q] = md_wa_i;
      wd_mem_d[wr_ptr_q] = md_wd_i;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // The counter only advances on cycles where a waiting FIFO entry loses to the ALU.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_eff && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
    err_d = err_q || (alu_valid_i && alu_stall_o);
  end

  always_comb begin
    busy_o = 1'b0;
    if (chk_ra_i != 5'd0) begin
      if (regwrite_q && (wa_q == chk_ra_i)) begin
        busy_o = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((i < int'(count_q)) && (wa_mem_q[rd_ptr_q + PW'(i)] == chk_ra_i)) begin
          busy_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        wa_mem_q[i] <= '0;
        wd_mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      wa_mem_q   <= wa_mem_d;
      wd_mem_q   <= wd_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
    end
  end

  assign RegWrite_o = regwrite_q;
  assign wa_o       = wa_q;
  assign wd_o       = wd_q;
  assign count_o    = count_q;
  assign err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table plus hand sequences for starvation, push/pop and reset.
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i;
  logic [4:0]  alu_wa_i;
  logic [31:0] alu_wd_i;
  logic        md_valid_i;
  logic        md_ready_o;
  logic [4:0]  md_wa_i;
  logic [31:0] md_wd_i;
  logic [4:0]  chk_ra_i;
  logic        busy_o;
  logic        alu_stall_o;
  logic        RegWrite_o;
  logic [4:0]  wa_o;
  logic [31:0] wd_o;
  logic [2:0]  count_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_wa_i(alu_wa_i), .alu_wd_i(alu_wd_i),
    .md_valid_i(md_valid_i), .md_ready_o(md_ready_o), .md_wa_i(md_wa_i), .md_wd_i(md_wd_i),
    .chk_ra_i(chk_ra_i), .busy_o(busy_o), .alu_stall_o(alu_stall_o),
    .RegWrite_o(RegWrite_o), .wa_o(wa_o), .wd_o(wd_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  awa;
    logic [31:0] awd;
    logic        mv;
    logic [4:0]  mwa;
    logic [31:0] mwd;
    logic [4:0]  chk;
    logic        e_rw;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_busy;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] awa, input logic [31:0] awd,
                       input logic mv, input logic [4:0] mwa, input logic [31:0] mwd);
    alu_valid_i = av; alu_wa_i = awa; alu_wd_i = awd;
    md_valid_i  = mv; md_wa_i  = mwa; md_wd_i  = mwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    chk_ra_i = 5'd0;
    #1;
    do_reset();

    chk("rst_rw", RegWrite_o, 1'b0);
    chk("rst_wa", wa_o, 5'd0);
    chk("rst_wd", wd_o, 32'd0);
    chk("rst_cnt", count_o, 3'd0);
    chk("rst_rdy", md_ready_o, 1'b1);
    chk("rst_err", err_o, 1'b0);
    for (int r = 0; r < 32; r++) begin
      chk_ra_i = 5'(r);
      #1;
      chk("rst_busy", busy_o, 1'b0);
    end

    //           av   awa    awd            mv   mwa    mwd            chk   rw   wa     wd             cnt   rdy  busy
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd0, 1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0,  32'h0,        5'd5, 1'b1, 5'd5,  32'h12345678, 3'd0, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 5'd0, 32'hAAAA,     1'b0, 5'd0,  32'h0,        5'd5, 1'b0, 5'd5,  32'h12345678, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 5'd2, 32'h200,      1'b1, 5'd8,  32'h800,      5'd9, 1'b1, 5'd2,  32'h200,      3'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'd2, 32'h201,      1'b1, 5'd9,  32'h801,      5'd9, 1'b1, 5'd2,  32'h201,      3'd2, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 5'd2, 32'h202,      1'b1, 5'd10, 32'h802,      5'd9, 1'b1, 5'd2,  32'h202,      3'd3, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 5'd2, 32'h203,      1'b1, 5'd11, 32'h803,      5'd9, 1'b1, 5'd2,  32'h203,      3'd4, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd9, 1'b1, 5'd8,  32'h800,      3'd3, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd9, 1'b1, 5'd9,  32'h801,      3'd2, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd9, 1'b1, 5'd10, 32'h802,      3'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd9, 1'b1, 5'd11, 32'h803,      3'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd9, 1'b0, 5'd11, 32'h803,      3'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  32'hDEAD,     5'd0, 1'b0, 5'd11, 32'h803,      3'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  32'h777,      5'd7, 1'b0, 5'd11, 32'h803,      3'd1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd7, 1'b1, 5'd7,  32'h777,      3'd0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd7, 1'b0, 5'd7,  32'h777,      3'd0, 1'b1, 1'b0};

    for (int v = 0; v < 16; v++) begin
      drive(vecs[v].av, vecs[v].awa, vecs[v].awd, vecs[v].mv, vecs[v].mwa, vecs[v].mwd);
      chk_ra_i = vecs[v].chk;
      tick();
      chk($sformatf("v%0d_rw", v),    RegWrite_o,  vecs[v].e_rw);
      chk($sformatf("v%0d_wa", v),    wa_o,        vecs[v].e_wa);
      chk($sformatf("v%0d_wd", v),    wd_o,        vecs[v].e_wd);
      chk($sformatf("v%0d_cnt", v),   count_o,     vecs[v].e_cnt);
      chk($sformatf("v%0d_rdy", v),   md_ready_o,  vecs[v].e_rdy);
      chk($sformatf("v%0d_busy", v),  busy_o,      vecs[v].e_busy);
      chk($sformatf("v%0d_stall", v), alu_stall_o, 1'b0);
    end

    // Starvation: one buffered entry, ALU valid every cycle.
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h333);
    tick();
    chk("st_push_cnt", count_o, 3'd1);
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("st_win%0d_wa", k), wa_o, 5'd4);
      chk($sformatf("st_win%0d_stall", k), alu_stall_o, (k == 8) ? 1'b1 : 1'b0);
    end
    chk("st_err_before", err_o, 1'b0);
    tick();
    chk("st_drain_rw", RegWrite_o, 1'b1);
    chk("st_drain_wa", wa_o, 5'd3);
    chk("st_drain_wd", wd_o, 32'h333);
    chk("st_after_stall", alu_stall_o, 1'b0);
    chk("st_after_cnt", count_o, 3'd0);
    chk("st_err_set", err_o, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("st_err_sticky", err_o, 1'b1);
    do_reset();
    chk("st_err_cleared", err_o, 1'b0);

    // Simultaneous push and pop at count 2.
    drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd20, 32'hA0);
    tick();
    drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd21, 32'hA1);
    tick();
    chk("pp_fill_cnt", count_o, 3'd2);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'hA2);
    tick();
    chk("pp_wa", wa_o, 5'd20);
    chk("pp_wd", wd_o, 32'hA0);
    chk("pp_cnt", count_o, 3'd2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("pp_d1_wa", wa_o, 5'd21);
    tick();
    chk("pp_d2_wa", wa_o, 5'd22);
    chk("pp_d2_wd", wd_o, 32'hA2);
    chk("pp_d2_cnt", count_o, 3'd0);

    // Reset while three entries are buffered.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd2, 32'h1, 1'b1, 5'(25 + k), 32'hB0 + 32'(k));
      tick();
    end
    chk("rm_cnt", count_o, 3'd3);
    do_reset();
    chk("rm_rst_cnt", count_o, 3'd0);
    chk("rm_rst_rw", RegWrite_o, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rm_idle%0d_rw", k), RegWrite_o, 1'b0);
      chk($sformatf("rm_idle%0d_cnt", k), count_o, 3'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
